// File: rtl/riscv_mdu.sv
// Iterative RV32M-style multiply/divide unit: one radix-2 step per cycle.
// Shift-add multiply and restoring divide on operand magnitudes, with the sign fixed up at the end.
module riscv_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic [1:0]      dbg_state_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Handshakes: a request transfers on a rising edge with valid_i && ready_o && !kill_i;
  // a result transfers on a rising edge with valid_o && ready_i; kill_i ends any operation.
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   acc_q, lo_q, opnd_q, result_q;

  logic              accept;
  logic              sign_a, sign_b, div_zero, div_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;

  logic [XLEN:0]     sum, shifted;
  logic              borrow;
  logic [XLEN-1:0]   diff, acc_n, lo_n, div_raw, div_s, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  assign accept = (state_q == IDLE) && valid_i && !kill_i;

  always_comb begin
    sign_a      = a_i[XLEN-1] && ((op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6));
    sign_b      = b_i[XLEN-1] && ((op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6));
    a_mag       = sign_a ? -a_i : a_i;
    b_mag       = sign_b ? -b_i : b_i;
    div_zero    = op_i[2] && (b_i == '0);
    div_ovf     = op_i[2] && !op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == {XLEN{1'b1}});
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)     special_res = op_i[1] ? a_i : {XLEN{1'b1}};
    else if (div_ovf) special_res = op_i[1] ? '0 : a_i;
  end

  // One iteration step; the divide borrow decides whether the trial subtraction is kept.
  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q, lo_q[XLEN-1]};
    borrow  = shifted < {1'b0, opnd_q};
    diff    = shifted[XLEN-1:0] - opnd_q;
    if (op_q[2]) begin
      acc_n = borrow ? shifted[XLEN-1:0] : diff;
      lo_n  = {lo_q[XLEN-2:0], ~borrow};
    end else begin
      acc_n = sum[XLEN:1];
      lo_n  = {sum[0], lo_q[XLEN-1:1]};
    end
    prod    = {acc_n, lo_n};
    prod_s  = neg_q ? -prod : prod;
    div_raw = op_q[1] ? acc_n : lo_n;
    div_s   = neg_q ? -div_raw : div_raw;
    if (op_q[2])                final_res = div_s;
    else if (op_q[1:0] == 2'b00) final_res = prod_s[XLEN-1:0];
    else                         final_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : BUSY;
      BUSY: begin
        if (kill_i)                   state_d = IDLE;
        else if (cnt_q == CW'(1))     state_d = DONE;
      end
      DONE: if (kill_i || ready_i)    state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= op_i;
      // Quotient takes the XOR of signs, remainder follows the dividend.
      neg_q  <= (op_i[2] && op_i[1]) ? sign_a : (sign_a ^ sign_b);
      acc_q  <= '0;
      lo_q   <= a_mag;
      opnd_q <= b_mag;
      if (special) begin
        cnt_q    <= '0;
        result_q <= special_res;
      end else begin
        cnt_q <= CW'(XLEN);
      end
    end else if (state_q == BUSY) begin
      if (kill_i) begin
        cnt_q <= '0;
      end else begin
        acc_q <= acc_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) result_q <= final_res;
      end
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign valid_o     = (state_q == DONE);
  assign result_o    = result_q;
  assign zero_o      = (result_q == '0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// Directed bench for riscv_mdu (XLEN=32): a driver issues requests and queues the expected
// results; a monitor compares every presented result against the head of the queue.
module tb_riscv_mdu;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [2:0]      op_i = '0;
  logic [XLEN-1:0] a_i = '0;
  logic [XLEN-1:0] b_i = '0;
  logic            kill_i = 1'b0;
  logic            valid_o;
  logic            ready_i = 1'b1;
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic [1:0]      dbg_state_o;

  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              acc_cyc = 0;
  bit              first = 1'b1;

  riscv_mdu #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .kill_i(kill_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and cycle counter
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: waits for ready_o, presents one request, scrambles operands after acceptance.
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int lat, input bit keep);
    int t = 0;
    while (!ready_o && t < 200) begin
      @(posedge clk_i); #1;
      t++;
    end
    check("issue_ready_timeout", ready_o, 1'b1);
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    op_i = 3'($urandom_range(0, 7));
    a_i  = $urandom;
    b_i  = $urandom;
    acc_cyc = cyc;
    if (keep) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
    end
    check("accepted", ready_o, 1'b0);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk_i); #1;
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk_i) begin
    if (rst_n_i && valid_o) begin
      if (exp_q.size() == 0) begin
        check("valid_without_pending_request", valid_o, 1'b0);
      end else begin
        check("result", result_o, exp_q[0]);
        check("zero_flag", zero_o, exp_q[0] == '0);
        if (first) begin
          check("latency", cyc - acc_cyc + 1, lat_q[0]);
          first = 1'b0;
        end
        if (ready_i || kill_i) begin
          void'(exp_q.pop_front());
          void'(lat_q.pop_front());
          first = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_result", result_o, 32'h0);
    check("rst_zero", zero_o, 1'b1);
    check("rst_state", dbg_state_o, 2'd0);
    wait_cycles(2);
    rst_n_i = 1'b1;
    wait_cycles(1);

    // Multiply
    issue(3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b1);
    issue(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b1);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b1);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 1'b1);
    issue(3'd3, 32'h00010000, 32'h00010000, 32'h00000001, 33, 1'b1);
    issue(3'd0, 32'h12345678, 32'h00000000, 32'h00000000, 33, 1'b1);
    // Divide
    issue(3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 1'b1);
    issue(3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, 1'b1);
    issue(3'd5, 32'd100,      32'd7,        32'd14,       33, 1'b1);
    issue(3'd7, 32'd100,      32'd7,        32'd2,        33, 1'b1);
    issue(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b1);
    issue(3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33, 1'b1);
    issue(3'd5, 32'd10,       32'hFFFFFFFF, 32'h00000000, 33, 1'b1);
    issue(3'd7, 32'd10,       32'hFFFFFFFF, 32'h0000000A, 33, 1'b1);
    // Special cases complete one cycle after acceptance
    issue(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1'b1);
    issue(3'd7, 32'd5,        32'd0,        32'h00000005, 1, 1'b1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b1);
    issue(3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1, 1'b1);
    issue(3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1, 1'b1);
    drain();

    // Consumer stalls 10 cycles in DONE, then kill and ready together
    ready_i = 1'b0;
    issue(3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1);
    wait_cycles(32);
    check("stall_valid", valid_o, 1'b1);
    wait_cycles(10);
    check("stall_valid_held", valid_o, 1'b1);
    check("stall_result_held", result_o, 32'hFFFFFFEB);
    kill_i = 1'b1; ready_i = 1'b1;
    wait_cycles(1);
    kill_i = 1'b0;
    check("kill_done_valid", valid_o, 1'b0);
    check("kill_done_ready", ready_o, 1'b1);
    check("kill_done_consumed_once", exp_q.size(), 0);

    // Kill in IDLE blocks acceptance
    op_i = 3'd0; a_i = 32'd3; b_i = 32'd4; valid_i = 1'b1; kill_i = 1'b1;
    wait_cycles(1);
    valid_i = 1'b0; kill_i = 1'b0;
    check("kill_idle_blocks", ready_o, 1'b1);

    // Kill at BUSY cycle 5
    issue(3'd0, 32'h00001234, 32'h00005678, 32'h0, 33, 1'b0);
    wait_cycles(4);
    check("busy_before_kill", dbg_state_o, 2'd1);
    kill_i = 1'b1;
    wait_cycles(1);
    kill_i = 1'b0;
    check("kill_busy_ready", ready_o, 1'b1);
    check("kill_busy_valid", valid_o, 1'b0);
    issue(3'd0, 32'd3, 32'd4, 32'd12, 33, 1'b1);
    drain();

    // Asynchronous reset mid-BUSY, then acceptance on the first edge after release
    issue(3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    wait_cycles(3);
    #3 rst_n_i = 1'b0;
    #1;
    check("async_rst_ready", ready_o, 1'b1);
    check("async_rst_valid", valid_o, 1'b0);
    check("async_rst_result", result_o, 32'h0);
    check("async_rst_zero", zero_o, 1'b1);
    wait_cycles(2);
    rst_n_i = 1'b1;
    issue(3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 1'b1);
    drain();
    wait_cycles(40);
    check("idle_after_drain", ready_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
